shift_reg_univ: RTL

SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

---
 rtl/shift_reg_pkg.sv | 21 ++
 rtl/shift_reg_univ.sv | 133 +++++++++++++
 2 files changed

// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation encodings
// and controller states.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    OP_HOLD  = 3'b000,
    OP_LOAD  = 3'b001,
    OP_SHR   = 3'b010,
    OP_SHL   = 3'b011,
    OP_ROR   = 3'b100,
    OP_ROL   = 3'b101,
    OP_ASR   = 3'b110,
    OP_BURST = 3'b111
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

endpackage : shift_reg_pkg

// File: rtl/shift_reg_univ.sv
// Universal shift register with a self-timed serialising burst mode.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | op/en decoded each edge: hold, load, shifts, rotates, burst
//   ST_BURST | one serial step per enabled edge, WIDTH steps, then done
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic             serial_in,
  output logic [WIDTH-1:0] out,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  // Counter value just before the final step; the final step lands on WIDTH.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e           r_state;
  logic [WIDTH-1:0] r_out;
  logic             r_so;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;

  state_e           w_state_nxt;
  logic [WIDTH-1:0] w_out_nxt;
  logic             w_so_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Next-value decode for the datapath, step counter and status flags.
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_so_nxt    = r_so;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          case (op_e'(op))
            OP_HOLD: ;
            OP_LOAD: w_out_nxt = data;
            OP_SHR: begin
              w_out_nxt = {serial_in, r_out[WIDTH-1:1]};
              w_so_nxt  = r_out[0];
            end
            OP_SHL: begin
              w_out_nxt = {r_out[WIDTH-2:0], serial_in};
              w_so_nxt  = r_out[WIDTH-1];
            end
            OP_ROR: begin
              w_out_nxt = {r_out[0], r_out[WIDTH-1:1]};
              w_so_nxt  = r_out[0];
            end
            OP_ROL: begin
              w_out_nxt = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
              w_so_nxt  = r_out[WIDTH-1];
            end
            OP_ASR: begin
              w_out_nxt = {r_out[WIDTH-1], r_out[WIDTH-1:1]};
              w_so_nxt  = r_out[0];
            end
            OP_BURST: begin
              w_out_nxt   = data;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_BURST;
              w_busy_nxt  = 1'b1;
            end
            default: ;
          endcase
        end
      end
      ST_BURST: begin
        // en low stalls the burst with everything held.
        if (en) begin
          if (LSB_FIRST) begin
            w_out_nxt = {serial_in, r_out[WIDTH-1:1]};
            w_so_nxt  = r_out[0];
          end else begin
            w_out_nxt = {r_out[WIDTH-2:0], serial_in};
            w_so_nxt  = r_out[WIDTH-1];
          end
          w_cnt_nxt = r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any burst without a done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_so    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_so    <= w_so_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign out        = r_out;
  assign serial_out = r_so;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule : shift_reg_univ
